// File: rtl/testeio_ack_handshake_ctrl_pkg.sv
// Shared types and register map for the testeio ack/data handshake controller.
package testeio_ack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CTRL    = 2'd2;
  localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_TIMEOUT  = 1;
  localparam int STAT_OVERFLOW = 2;
  localparam int STAT_DONE     = 3;
  localparam int STAT_LVL_LSB  = 8;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_IRQ_EN = 2;

endpackage

// File: rtl/testeio_ack_handshake_ctrl_if.sv
// Avalon s1 register bus plus the external req/ack/data lines of the handshake controller.
interface testeio_ack_handshake_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              ext_ack;
  logic [DATA_W-1:0] ext_rdata;
  logic              out_req;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  address, chipselect, write_n, writedata, ext_ack, ext_rdata,
    output readdata, out_req, out_data
  );

  modport master (
    output address, chipselect, write_n, writedata, ext_ack, ext_rdata,
    input  readdata, out_req, out_data
  );
endinterface

// File: rtl/testeio_ack_handshake_ctrl_fifo.sv
// First-word-fall-through TX FIFO; dout shows the head, updates one cycle after push/pop.
// A push while full is accepted only when a pop frees a slot the same cycle; flush wins over both.
module testeio_ack_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  input  logic [DATA_W-1:0]             din,
  output logic [DATA_W-1:0]             dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              do_push, do_pop;

  assign full    = (level_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~flush & (~full | pop);
  assign do_pop  = pop & ~empty & ~flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/testeio_ack_handshake_ctrl.sv
// Avalon-MM s1 slave running a 4-phase req/ack handshake per queued word; ack seen 2 cycles late
// via synchronizer, no bus backpressure (full FIFO drops + flags). TESTEIO_ACK_CTRL_IRQ_EN adds irq.
module testeio_ack_handshake_ctrl
  import testeio_ack_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TO_W       = 16
) (
  input  logic clk,
  input  logic reset,
`ifdef TESTEIO_ACK_CTRL_IRQ_EN
  output logic irq,
`endif
  testeio_ack_handshake_ctrl_if.slave bus
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic              out_req_q, out_req_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [TO_W-1:0]   limit_q, limit_d;
  logic              enable_q, enable_d;
  logic              irq_en_q, irq_en_d;
  logic              timeout_q, timeout_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;
  logic              ack_meta_q, ack_meta_d;
  logic              ack_s_q, ack_s_d;

  logic              wr, wr_data, wr_stat, wr_ctrl, wr_to;
  logic              flush, push, pop, timeout_hit;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full, fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  logic [31:0]       rdata;
  logic              unused_wd;

  assign wr          = bus.chipselect & ~bus.write_n;
  assign wr_data     = wr & (bus.address == ADDR_DATA);
  assign wr_stat     = wr & (bus.address == ADDR_STATUS);
  assign wr_ctrl     = wr & (bus.address == ADDR_CTRL);
  assign wr_to       = wr & (bus.address == ADDR_TIMEOUT);
  assign flush       = wr_ctrl & bus.writedata[CTRL_FLUSH];
  assign push        = wr_data & ~flush;
  assign timeout_hit = (limit_q != '0) && (cnt_q == limit_q - TO_W'(1));
  assign unused_wd   = ^bus.writedata;

  testeio_ack_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .din  (bus.writedata[DATA_W-1:0]),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(fifo_level)
  );

  always_comb begin
    state_d    = state_q;
    out_req_d  = out_req_q;
    out_data_d = out_data_q;
    rx_data_d  = rx_data_q;
    cnt_d      = cnt_q;
    limit_d    = limit_q;
    enable_d   = enable_q;
    irq_en_d   = irq_en_q;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    done_d     = done_q;
    ack_meta_d = bus.ext_ack;
    ack_s_d    = ack_meta_q;
    pop        = 1'b0;

    if (wr_ctrl) begin
      enable_d = bus.writedata[CTRL_EN];
`ifdef TESTEIO_ACK_CTRL_IRQ_EN
      irq_en_d = bus.writedata[CTRL_IRQ_EN];
`else
      irq_en_d = 1'b0;
`endif
    end
    if (wr_to) begin
      limit_d = bus.writedata[TO_W-1:0];
    end
    // Clear first so that a same-cycle hardware event still leaves its sticky bit set.
    if (wr_stat) begin
      if (bus.writedata[STAT_TIMEOUT])  timeout_d  = 1'b0;
      if (bus.writedata[STAT_OVERFLOW]) overflow_d = 1'b0;
      if (bus.writedata[STAT_DONE])     done_d     = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (enable_q && !fifo_empty) begin
          pop        = 1'b1;
          out_data_d = fifo_dout;
          out_req_d  = 1'b1;
          cnt_d      = '0;
          state_d    = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (ack_s_q) begin
          rx_data_d = bus.ext_rdata;
          out_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = REL;
        end else if (timeout_hit) begin
          timeout_d = 1'b1;
          out_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      REL: begin
        cnt_d = cnt_q + 1'b1;
        if (!ack_s_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (timeout_hit) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      pop       = 1'b0;
      out_req_d = 1'b0;
      state_d   = IDLE;
    end

    if (push && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
  end

`ifdef TESTEIO_ACK_CTRL_IRQ_EN
  logic irq_q, irq_d;
  assign irq_d = irq_en_d & (done_d | timeout_d | overflow_d);
  assign irq   = irq_q;

  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      out_req_q  <= 1'b0;
      out_data_q <= '0;
      rx_data_q  <= '0;
      cnt_q      <= '0;
      limit_q    <= '0;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_req_q  <= out_req_d;
      out_data_q <= out_data_d;
      rx_data_q  <= rx_data_d;
      cnt_q      <= cnt_d;
      limit_q    <= limit_d;
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      ack_meta_q <= ack_meta_d;
      ack_s_q    <= ack_s_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.address)
      ADDR_DATA:   rdata[DATA_W-1:0] = rx_data_q;
      ADDR_STATUS: begin
        rdata[STAT_BUSY]                = (state_q != IDLE);
        rdata[STAT_TIMEOUT]             = timeout_q;
        rdata[STAT_OVERFLOW]            = overflow_q;
        rdata[STAT_DONE]                = done_q;
        rdata[STAT_LVL_LSB +: 8]        = 8'(fifo_level);
      end
      ADDR_CTRL: begin
        rdata[CTRL_EN]     = enable_q;
        rdata[CTRL_IRQ_EN] = irq_en_q;
      end
      default:     rdata[TO_W-1:0] = limit_q;
    endcase
  end

  assign bus.readdata = rdata;
  assign bus.out_req  = out_req_q;
  assign bus.out_data = out_data_q;

endmodule

// File: tb/tb_testeio_ack_handshake_ctrl.sv
// Directed bench: register access, handshakes against an external ack model, overflow, timeout, flush, irq.
module tb_testeio_ack_handshake_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
`ifdef TESTEIO_ACK_CTRL_IRQ_EN
  logic irq;
`endif
  int total = 0;
  int bad = 0;

  logic       model_on = 1'b0;
  logic [7:0] model_rdata = 8'h00;
  logic [7:0] seen[$];
  int         req_hi_cnt = 0;

  testeio_ack_handshake_ctrl_if #(.DATA_W(8)) bus ();

  testeio_ack_handshake_ctrl dut (
    .clk  (clk),
    .reset(reset),
`ifdef TESTEIO_ACK_CTRL_IRQ_EN
    .irq  (irq),
`endif
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // External circuit: raises ack ~3 cycles after out_req, drops it once out_req falls.
  initial begin : ext_model
    int dly;
    dly = 0;
    bus.ext_ack   = 1'b0;
    bus.ext_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.ext_ack) begin
        if (!bus.out_req) bus.ext_ack = 1'b0;
      end else if (model_on && bus.out_req) begin
        if (dly == 2) begin
          bus.ext_ack   = 1'b1;
          bus.ext_rdata = model_rdata;
          seen.push_back(bus.out_data);
          dly = 0;
        end else begin
          dly++;
        end
      end else begin
        dly = 0;
      end
    end
  end

  initial begin : req_monitor
    forever begin
      @(negedge clk);
      if (bus.out_req === 1'b1) req_hi_cnt++;
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1 d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic do_reset();
    model_on = 1'b0;
    @(negedge clk);
    reset          = 1'b1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    do_reset();
    total++; if (bus.out_req !== 1'b0) begin bad++; $display("FAIL rst_out_req got=%b exp=0", bus.out_req); end
    total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data got=%h exp=00", bus.out_data); end
    rd(2'd0, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", r); end
    rd(2'd1, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL rst_status got=%h exp=0", r); end
    rd(2'd2, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL rst_ctrl got=%h exp=0", r); end
    rd(2'd3, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL rst_timeout got=%h exp=0", r); end
  endtask

  task automatic test_basic_handshake();
    logic [31:0] r;
    int base;
    do_reset();
    base = seen.size();
    model_on = 1'b1; model_rdata = 8'h3C;
    wr(2'd2, 32'h1);
    wr(2'd0, 32'hA5);
    repeat (30) @(negedge clk);
    total++; if (seen.size() != base + 1 || seen[base] !== 8'hA5) begin bad++; $display("FAIL t1_word got_n=%0d exp_n=%0d", seen.size() - base, 1); end
    total++; if (bus.out_data !== 8'hA5) begin bad++; $display("FAIL t1_out_data got=%h exp=a5", bus.out_data); end
    total++; if (bus.out_req !== 1'b0) begin bad++; $display("FAIL t1_out_req got=%b exp=0", bus.out_req); end
    rd(2'd1, r);
    total++; if (r !== 32'h8) begin bad++; $display("FAIL t1_status got=%h exp=8", r); end
    rd(2'd0, r);
    total++; if (r !== 32'h3C) begin bad++; $display("FAIL t1_rx_data got=%h exp=3c", r); end
  endtask

  task automatic test_overflow_order();
    logic [31:0] r;
    int base;
    do_reset();
    base = seen.size();
    for (int i = 1; i <= 5; i++) wr(2'd0, 32'(i));
    rd(2'd1, r);
    total++; if (r !== 32'h0404) begin bad++; $display("FAIL t2_full_status got=%h exp=404", r); end
    model_on = 1'b1; model_rdata = 8'h99;
    wr(2'd2, 32'h1);
    repeat (120) @(negedge clk);
    total++; if (seen.size() != base + 4) begin bad++; $display("FAIL t2_count got=%0d exp=4", seen.size() - base); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (seen.size() <= base + i || seen[base + i] !== 8'(i + 1)) begin
        bad++; $display("FAIL t2_order idx=%0d exp=%0d", i, i + 1);
      end
    end
    rd(2'd1, r);
    total++; if (r !== 32'h000C) begin bad++; $display("FAIL t2_end_status got=%h exp=c", r); end
  endtask

  task automatic test_timeout();
    logic [31:0] r;
    int base, c0;
    do_reset();
    base = seen.size();
    wr(2'd3, 32'd10);
    wr(2'd2, 32'h1);
    c0 = req_hi_cnt;
    wr(2'd0, 32'h11);
    repeat (40) @(negedge clk);
    total++; if (req_hi_cnt - c0 != 10) begin bad++; $display("FAIL t3_req_cycles got=%0d exp=10", req_hi_cnt - c0); end
    rd(2'd1, r);
    total++; if (r !== 32'h2) begin bad++; $display("FAIL t3_status got=%h exp=2", r); end
    rd(2'd3, r);
    total++; if (r !== 32'd10) begin bad++; $display("FAIL t3_limit got=%h exp=a", r); end
    total++; if (seen.size() != base) begin bad++; $display("FAIL t3_acks got=%0d exp=0", seen.size() - base); end
  endtask

  task automatic test_flush();
    logic [31:0] r;
    int base;
    do_reset();
    wr(2'd2, 32'h1);
    wr(2'd0, 32'h21);
    wr(2'd0, 32'h22);
    repeat (3) @(negedge clk);
    total++; if (bus.out_req !== 1'b1) begin bad++; $display("FAIL t4_pre_req got=%b exp=1", bus.out_req); end
    wr(2'd2, 32'h3);
    total++; if (bus.out_req !== 1'b0) begin bad++; $display("FAIL t4_flush_req got=%b exp=0", bus.out_req); end
    rd(2'd1, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL t4_flush_status got=%h exp=0", r); end
    base = seen.size();
    model_on = 1'b1; model_rdata = 8'h5A;
    wr(2'd0, 32'h33);
    repeat (30) @(negedge clk);
    total++; if (seen.size() != base + 1 || seen[base] !== 8'h33) begin bad++; $display("FAIL t4_after_word got_n=%0d exp_n=1", seen.size() - base); end
    rd(2'd0, r);
    total++; if (r !== 32'h5A) begin bad++; $display("FAIL t4_rx_data got=%h exp=5a", r); end
  endtask

  task automatic test_full_pop_push();
    logic [31:0] r;
    do_reset();
    for (int i = 0; i < 4; i++) wr(2'd0, 32'h41 + 32'(i));
    // CTRL write then DATA write on the very next cycle, which is the first pop cycle.
    @(negedge clk);
    bus.address = 2'd2; bus.writedata = 32'h1; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.address = 2'd0; bus.writedata = 32'h45;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
    rd(2'd1, r);
    total++; if (r !== 32'h0401) begin bad++; $display("FAIL t5_coincident got=%h exp=401", r); end
    wr(2'd0, 32'h46);
    rd(2'd1, r);
    total++; if (r !== 32'h0405) begin bad++; $display("FAIL t5_overflow got=%h exp=405", r); end
    wr(2'd1, 32'hE);
    rd(2'd1, r);
    total++; if (r !== 32'h0401) begin bad++; $display("FAIL t5_w1c got=%h exp=401", r); end
  endtask

  task automatic test_irq();
    logic [31:0] r;
    do_reset();
    model_on = 1'b1; model_rdata = 8'h12;
    wr(2'd2, 32'h5);
    rd(2'd2, r);
`ifdef TESTEIO_ACK_CTRL_IRQ_EN
    total++; if (r !== 32'h5) begin bad++; $display("FAIL t6_ctrl got=%h exp=5", r); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL t6_irq_idle got=%b exp=0", irq); end
    wr(2'd0, 32'h77);
    repeat (30) @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL t6_irq_set got=%b exp=1", irq); end
    wr(2'd1, 32'h8);
    #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL t6_irq_clr got=%b exp=0", irq); end
`else
    total++; if (r !== 32'h1) begin bad++; $display("FAIL t6_ctrl got=%h exp=1", r); end
    wr(2'd0, 32'h77);
    repeat (30) @(negedge clk);
    wr(2'd1, 32'h8);
    rd(2'd1, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL t6_done_clr got=%h exp=0", r); end
`endif
  endtask

  initial begin
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    test_reset();
    test_basic_handshake();
    test_overflow_order();
    test_timeout();
    test_flush();
    test_full_pop_push();
    test_irq();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
